// File: rtl/spiflash_pkg.sv
// Shared types and constants for the SPI/QSPI flash responder.
// Quad read support is built only with SPIFLASH_RESP_QUAD_EN defined.
package spiflash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'hEB;
  localparam logic [7:0] CMD_WAKE  = 8'hAB;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam int ADDR_W = 24;

  localparam int         MODE_CONT_MSB = 5;
  localparam int         MODE_CONT_LSB = 4;
  localparam logic [1:0] MODE_CONT_VAL = 2'b10;

  // Mode byte pattern 10 in bits [5:4] keeps continuous read armed
  function automatic logic mode_arms_cont(
    input logic [7:0] m
  );
    return m[MODE_CONT_MSB:MODE_CONT_LSB]
      == MODE_CONT_VAL;
  endfunction

endpackage

// File: rtl/spiflash_resp_if.sv
// Flash pin and backing-memory read port bundle.
// master = flash controller + memory, slave = responder.
interface spiflash_resp_if #(
  parameter int MEM_ABITS = 24
);

  logic                 spi_csb;
  logic                 spi_clk;
  logic [3:0]           spi_io_di;
  logic [3:0]           spi_io_do;
  logic [3:0]           spi_io_oe;
  logic [MEM_ABITS-1:0] mem_addr;
  logic [7:0]           mem_rdata;

  modport master (
    output spi_csb,
    output spi_clk,
    output spi_io_di,
    output mem_rdata,
    input  spi_io_do,
    input  spi_io_oe,
    input  mem_addr
  );

  modport slave (
    input  spi_csb,
    input  spi_clk,
    input  spi_io_di,
    input  mem_rdata,
    output spi_io_do,
    output spi_io_oe,
    output mem_addr
  );

endinterface

// File: rtl/spiflash_resp_shift.sv
// SCK rise detector, 1/4-bit input and output shifters, rise counter.
// Works for both single and quad lane widths (i_quad).
module spiflash_resp_shift
  import spiflash_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_sck,
  input  logic              i_clr,
  input  logic              i_quad,
  input  logic              i_cnt_en,
  input  logic              i_out_en,
  input  logic              i_load,
  input  logic [7:0]        i_load_data,
  input  logic [3:0]        i_di,
  output logic              o_rise,
  output logic [ADDR_W-1:0] o_in_next,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [3:0]        o_out_hi
);

  logic              r_sck_q;
  logic [ADDR_W-1:0] r_in_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_out_sr;
  logic              w_step;

  assign o_rise = i_sck && !r_sck_q;
  assign w_step = o_rise && i_cnt_en;

  assign o_in_next = i_quad
    ? {r_in_sr[ADDR_W-5:0], i_di}
    : {r_in_sr[ADDR_W-2:0], i_di[0]};

  assign o_cnt    = r_cnt;
  assign o_out_hi = r_out_sr[7:4];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_q <= 1'b0;
      r_in_sr <= '0;
      r_cnt   <= '0;
    end else begin
      r_sck_q <= i_sck;
      if (i_clr) begin
        r_in_sr <= '0;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_in_sr <= o_in_next;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  // Load wins over shift: it happens on the last rise of a byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_sr <= '0;
    end else if (i_load) begin
      r_out_sr <= i_load_data;
    end else if (o_rise && i_out_en) begin
      r_out_sr <= i_quad
        ? {r_out_sr[3:0], 4'b0000}
        : {r_out_sr[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spiflash_resp.sv
// SPI/QSPI flash responder: command FSM and address pointer.
// Define SPIFLASH_RESP_QUAD_EN to build the 0xEB quad read path.
module spiflash_resp
  import spiflash_pkg::*;
#(
  parameter int MEM_ABITS  = 24,
  parameter int QUAD_DUMMY = 8
) (
  input  logic             clk,
  input  logic             resetn,
  spiflash_resp_if.slave   bus,
  output logic             stat_awake,
  output logic             stat_cont
);

  localparam int CNT_W =
    (QUAD_DUMMY > 24) ? $clog2(QUAD_DUMMY + 1) : 5;

  localparam logic [CNT_W-1:0] N_CMD   = CNT_W'(7);
  localparam logic [CNT_W-1:0] N_ADDR1 = CNT_W'(23);
  localparam logic [CNT_W-1:0] N_ADDR4 = CNT_W'(5);
  localparam logic [CNT_W-1:0] N_DAT1  = CNT_W'(7);
  localparam logic [CNT_W-1:0] N_DAT4  = CNT_W'(1);

  state_t               r_state;
  state_t               w_state_n;
  logic [MEM_ABITS-1:0] r_addr;
  logic [MEM_ABITS-1:0] w_mem_addr;
  logic                 w_addr_we;
  logic                 r_awake;
  logic                 w_awake_set;
  logic                 w_quad;
  logic                 w_cont;
  logic                 w_rise;
  logic                 w_clr;
  logic                 w_load;
  logic                 w_cnt_en;
  logic                 w_out_en;
  logic                 w_last;
  logic [ADDR_W-1:0]    w_in_next;
  logic [CNT_W-1:0]     w_cnt;
  logic [CNT_W-1:0]     w_cnt_end;
  logic [3:0]           w_out_hi;
  logic [7:0]           w_cmd;

`ifdef SPIFLASH_RESP_QUAD_EN
  localparam logic [CNT_W-1:0] N_MODE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] N_DUMMY =
    CNT_W'(QUAD_DUMMY - 1);

  logic r_quad;
  logic w_quad_n;
  logic w_quad_we;
  logic r_cont;
  logic w_cont_set;
  logic w_cont_clr;

  assign w_quad = r_quad;
  assign w_cont = r_cont;
`else
  assign w_quad = 1'b0;
  assign w_cont = 1'b0;
`endif

  spiflash_resp_shift #(
    .CNT_W (CNT_W)
  ) u_shift (
    .clk         (clk),
    .resetn      (resetn),
    .i_sck       (bus.spi_clk),
    .i_clr       (w_clr),
    .i_quad      (w_quad),
    .i_cnt_en    (w_cnt_en),
    .i_out_en    (w_out_en),
    .i_load      (w_load),
    .i_load_data (bus.mem_rdata),
    .i_di        (bus.spi_io_di),
    .o_rise      (w_rise),
    .o_in_next   (w_in_next),
    .o_cnt       (w_cnt),
    .o_out_hi    (w_out_hi)
  );

  assign w_cmd  = w_in_next[7:0];
  assign w_last = w_rise && (w_cnt == w_cnt_end);

  always_comb begin
    w_cnt_end = N_CMD;
    case (r_state)
      ADDR:    w_cnt_end = w_quad ? N_ADDR4 : N_ADDR1;
`ifdef SPIFLASH_RESP_QUAD_EN
      MODE:    w_cnt_end = N_MODE;
      DUMMY:   w_cnt_end = N_DUMMY;
`endif
      DATA:    w_cnt_end = w_quad ? N_DAT4 : N_DAT1;
      default: w_cnt_end = N_CMD;
    endcase
  end

  always_comb begin
    w_state_n   = r_state;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_addr_we   = 1'b0;
    w_mem_addr  = r_addr;
    w_awake_set = 1'b0;
    w_cnt_en    = 1'b0;
    w_out_en    = 1'b0;
`ifdef SPIFLASH_RESP_QUAD_EN
    w_quad_n    = r_quad;
    w_quad_we   = 1'b0;
    w_cont_set  = 1'b0;
    w_cont_clr  = 1'b0;
`endif
    if (bus.spi_csb) begin
      w_state_n = IDLE;
      w_clr     = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_clr     = 1'b1;
          w_state_n = CMD;
`ifdef SPIFLASH_RESP_QUAD_EN
          w_quad_we = 1'b1;
          w_quad_n  = r_cont;
          if (r_cont) w_state_n = ADDR;
`endif
        end
        CMD: begin
          w_cnt_en = 1'b1;
          if (w_last) begin
            w_clr     = 1'b1;
            w_state_n = IGNORE;
            unique case (1'b1)
              (w_cmd == CMD_WAKE): w_awake_set = 1'b1;
              (w_cmd == CMD_RESET): begin
`ifdef SPIFLASH_RESP_QUAD_EN
                w_cont_clr = 1'b1;
`endif
              end
              (w_cmd == CMD_READ && r_awake):
                w_state_n = ADDR;
`ifdef SPIFLASH_RESP_QUAD_EN
              (w_cmd == CMD_QREAD && r_awake): begin
                w_state_n = ADDR;
                w_quad_we = 1'b1;
                w_quad_n  = 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        ADDR: begin
          w_cnt_en = 1'b1;
          if (w_last) begin
            w_clr      = 1'b1;
            w_load     = 1'b1;
            w_addr_we  = 1'b1;
            w_mem_addr = w_in_next[MEM_ABITS-1:0];
            w_state_n  = DATA;
`ifdef SPIFLASH_RESP_QUAD_EN
            if (r_quad) w_state_n = MODE;
`endif
          end
        end
`ifdef SPIFLASH_RESP_QUAD_EN
        MODE: begin
          w_cnt_en = 1'b1;
          if (w_last) begin
            w_clr      = 1'b1;
            w_cont_set = mode_arms_cont(w_cmd);
            w_cont_clr = !mode_arms_cont(w_cmd);
            w_state_n  = DUMMY;
          end
        end
        DUMMY: begin
          w_cnt_en = 1'b1;
          if (w_last) begin
            w_clr     = 1'b1;
            w_state_n = DATA;
          end
        end
`endif
        DATA: begin
          w_cnt_en = 1'b1;
          w_out_en = 1'b1;
          if (w_last) begin
            w_clr      = 1'b1;
            w_load     = 1'b1;
            w_addr_we  = 1'b1;
            w_mem_addr = r_addr + MEM_ABITS'(1);
          end
        end
        IGNORE: ;
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_awake <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_addr_we)   r_addr  <= w_mem_addr;
      if (w_awake_set) r_awake <= 1'b1;
    end
  end

`ifdef SPIFLASH_RESP_QUAD_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_quad <= 1'b0;
      r_cont <= 1'b0;
    end else begin
      if (w_quad_we) r_quad <= w_quad_n;
      if (w_cont_clr) r_cont <= 1'b0;
      else if (w_cont_set) r_cont <= 1'b1;
    end
  end
`endif

  // Drive only while streaming data; idle pins read as zero
  always_comb begin
    bus.spi_io_oe = 4'b0000;
    bus.spi_io_do = 4'b0000;
    if (r_state == DATA) begin
      if (w_quad) begin
        bus.spi_io_oe = 4'b1111;
        bus.spi_io_do = w_out_hi;
      end else begin
        bus.spi_io_oe = 4'b0010;
        bus.spi_io_do = {2'b00, w_out_hi[3], 1'b0};
      end
    end
  end

  assign bus.mem_addr = w_mem_addr;
  assign stat_awake   = r_awake;
  assign stat_cont    = w_cont;

endmodule
